hpf_z_packer: RTL and testbench
===============================

Name: hpf_z_packer

Overview:
- Downstream stage of the 16-tap high-pass filter.
- Captures each 8-bit filtered sample presented as a z/z_valid pulse and packs four consecutive samples into one 32-bit word.
- Buffers packed words in a small show-ahead FIFO and hands them to the result-memory writer over a valid/ready handshake.
- Supports flushing a partially filled word at end of frame.

Parameters:
- DEPTH, 4, number of FIFO word entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- z_valid  input  1  one-cycle pulse; z holds a valid filtered sample.
- z  input  8  filtered sample, treated as an opaque byte.
- flush  input  1  one-cycle pulse; emit the partial word now.
- w_valid  output  1  FIFO head entry is valid.
- w_ready  input  1  consumer accepts the head entry this cycle.
- w_data  output  32  head word; lane0 = bits 7:0 = oldest sample.
- w_bytes  output  3  number of valid lanes in the head word (1..4).
- level  output  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a word was dropped.
- sample_cnt  output  16  count of accepted z_valid pulses; wraps at 16 bits.

Behaviour:
- One clock. Reset is asynchronous and active-high. All state is cleared on reset.
- Reset values: w_valid=0, w_data=0, w_bytes=0, level=0, overflow=0, sample_cnt=0. Lane counter=0, pack register=0.
- Reset mid-operation discards the partial word and all FIFO contents. No word is emitted for them.
- Pack register (32 b) plus lane counter (0..3), acting as a 4-state FSM: LANE0 -> LANE1 -> LANE2 -> LANE3 -> LANE0.
- On z_valid in state LANEk:
  - z is written into lane k, and sample_cnt increments.
  - For k<3: advance to LANE(k+1).
  - For k=3: push {pack with z in lane 3, w_bytes=4} to the FIFO, clear the pack register, return to LANE0.
- On flush with lane count n>0 and no z_valid: push {pack, unused lanes zero, w_bytes=n}, clear the pack register, go to LANE0.
- On flush and z_valid in the same cycle: z is included first.
  - If this fills lane 3, a single word with w_bytes=4 is pushed.
  - Otherwise one word with w_bytes=n+1 is pushed.
  - Only one push occurs.
- flush in LANE0 with no z_valid: no push, no effect.
- Push timing: the push is registered. The word is visible at the FIFO head (w_valid=1) on the cycle after the completing z_valid/flush, if the FIFO was empty.
- FIFO is show-ahead.
  - w_data and w_bytes always reflect the head entry.
  - When empty: w_valid=0, w_data=0, w_bytes=0.
  - Pop occurs when w_valid && w_ready. The next entry appears the following cycle.
  - w_ready while empty is ignored.
- Simultaneous push and pop:
  - When full: both succeed, level unchanged, no overflow.
  - When empty: the pushed word becomes head next cycle, level=1.
- Push while full and no pop: the word is dropped, overflow is set, and FIFO contents are unchanged.
- overflow stays set until reset.
- Read/write pointers are ADDR_W bits and wrap modulo DEPTH. level is tracked separately, to distinguish full from empty.
- sample_cnt wraps 16'hFFFF -> 0. It is unaffected by flush and by overflow.
- Back-to-back z_valid on consecutive cycles is supported, even though the upstream filter spaces its outputs about 20 cycles apart.

Test Plan:
1. z_valid with z=11,22,33,44 (hex), w_ready=1 -> cycle after the 4th pulse: w_valid=1, w_data=32'h44332211, w_bytes=4; popped next cycle; level returns to 0; sample_cnt=4.
2. z=A1,B2 then flush (no z_valid) -> w_data=32'h0000B2A1, w_bytes=2. Then z=C3 with flush in the same cycle -> w_data=32'h000000C3, w_bytes=1. Only two words are pushed.
3. w_ready=0, push 5 full words with DEPTH=4 -> level=4, overflow=1 after the 5th push. Draining yields words 1-4 in order; word 5 is absent.
4. FIFO full, w_ready=1 held while a 4th byte arrives -> push and pop in the same cycle; level stays 4; overflow stays 0; order is preserved.
5. Assert reset after 2 bytes packed and 1 word queued -> all outputs 0 immediately. The next 4 bytes produce a word containing only the new bytes, with w_bytes=4.
6. 65537 z_valid pulses -> sample_cnt=1. flush with lane count 0 -> w_valid stays 0.

Source files
------------

// File: rtl/hpf_z_packer.sv
// hpf_z_packer
//   Packs the 8-bit output samples of the high-pass filter into 32-bit words.
//   Four samples make one word, and lane0 (bits 7:0) holds the oldest sample.
//   A flush pulse emits a partially filled word early; its unused lanes are zero.
//   Packed words go into a show-ahead FIFO that the result-memory writer drains.
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   z_valid, z       one-cycle sample strobe and sample byte
//   flush            one-cycle request to emit the partial word
//   w_valid/w_ready  handshake for the head word; pop on valid && ready
//   w_data, w_bytes  head word and its valid lane count; both zero when empty
//   level            FIFO occupancy, 0..DEPTH
//   overflow         sticky; a push was dropped because the FIFO was full
//   sample_cnt       accepted z_valid pulses, wraps at 16 bits
module hpf_z_packer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              z_valid,
  input  logic [7:0]        z,
  input  logic              flush,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic [2:0]        w_bytes,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [15:0]       sample_cnt
);

  typedef enum logic [1:0] {LANE0, LANE1, LANE2, LANE3} lane_e;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  lane_e             state_q, state_d;
  logic [31:0]       pack_q, pack_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q   [DEPTH];
  logic [2:0]        bytes_q [DEPTH];

  logic [31:0] pack_new;
  logic        push;
  logic [31:0] push_data;
  logic [2:0]  push_bytes;
  logic        full, empty, pop, wr_en;

  // Packer FSM: the state is the lane index that the next sample goes into.
  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_data  = '0;
    push_bytes = '0;
    pack_new   = pack_q;
    case (state_q)
      LANE0:   pack_new[7:0]   = z;
      LANE1:   pack_new[15:8]  = z;
      LANE2:   pack_new[23:16] = z;
      default: pack_new[31:24] = z;
    endcase

    if (z_valid) begin
      cnt_d = cnt_q + 16'd1;
      // A flush together with a sample includes that sample, and only one push happens.
      if (state_q == LANE3 || flush) begin
        push       = 1'b1;
        push_data  = pack_new;
        push_bytes = {1'b0, state_q} + 3'd1;
        pack_d     = '0;
        state_d    = LANE0;
      end else begin
        pack_d = pack_new;
        case (state_q)
          LANE0:   state_d = LANE1;
          LANE1:   state_d = LANE2;
          default: state_d = LANE3;
        endcase
      end
    end else if (flush && state_q != LANE0) begin
      push       = 1'b1;
      push_data  = pack_q;
      push_bytes = {1'b0, state_q};
      pack_d     = '0;
      state_d    = LANE0;
    end
  end

  // FIFO control. When the FIFO is full, a push is still accepted if a pop
  // happens in the same cycle: the write reuses the slot that is being read out.
  always_comb begin
    full       = (level_q == FULL_LVL);
    empty      = (level_q == '0);
    pop        = !empty && w_ready;
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop)
      level_d = level_q + (ADDR_W+1)'(1);
    else if (!wr_en && pop)
      level_d = level_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LANE0;
      pack_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        bytes_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (wr_en) begin
        mem_q[wr_ptr_q]   <= push_data;
        bytes_q[wr_ptr_q] <= push_bytes;
      end
    end
  end

  always_comb begin
    w_valid    = !empty;
    w_data     = empty ? '0 : mem_q[rd_ptr_q];
    w_bytes    = empty ? '0 : bytes_q[rd_ptr_q];
    level      = level_q;
    overflow   = overflow_q;
    sample_cnt = cnt_q;
  end

endmodule

// File: tb/tb_hpf_z_packer.sv
module tb_hpf_z_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        z_valid;
  logic [7:0]  z;
  logic        flush;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [2:0]  w_bytes;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] sample_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hpf_z_packer #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .z_valid    (z_valid),
    .z          (z),
    .flush      (flush),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_bytes    (w_bytes),
    .level      (level),
    .overflow   (overflow),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        zv;
    logic [7:0]  zz;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic [2:0]  el;
    logic        eo;
    logic [15:0] ec;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge, and outputs are sampled at that same point.
  task automatic cyc(input logic zv, input logic [7:0] zz, input logic fl, input logic rdy);
    z_valid = zv;
    z       = zz;
    flush   = fl;
    w_ready = rdy;
    @(posedge clk);
    #1;
    z_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] wd, input logic rdy_last);
    for (int j = 0; j < 4; j++)
      cyc(1'b1, wd[8*j +: 8], 1'b0, (j == 3) ? rdy_last : 1'b0);
  endtask

  task automatic drain_check(input string name, input logic [31:0] wd);
    chk({name, "_valid"}, {31'd0, w_valid}, 32'd1);
    chk({name, "_data"}, w_data, wd);
    chk({name, "_bytes"}, {29'd0, w_bytes}, 32'd4);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  logic [31:0] words [5];

  initial begin
    reset   = 1'b1;
    z_valid = 1'b0;
    z       = '0;
    flush   = 1'b0;
    w_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_data", w_data, 32'd0);
    chk("rst_bytes", {29'd0, w_bytes}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //             zv   z      fl  rdy  ev  data            b     lvl   ovf  cnt
    vec[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd1};
    vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd2};
    vec[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd3};
    vec[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 3'd4, 3'd1, 1'b0, 16'd4};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd4};
    vec[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd5};
    vec[6]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd6};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000B2A1, 3'd2, 3'd1, 1'b0, 16'd6};
    vec[8]  = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 32'h0000B2A1, 3'd2, 3'd2, 1'b0, 16'd7};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h000000C3, 3'd1, 3'd1, 1'b0, 16'd7};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd7};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 3'd0, 1'b0, 16'd7};

    for (int i = 0; i < 12; i++) begin
      cyc(vec[i].zv, vec[i].zz, vec[i].fl, vec[i].rdy);
      chk($sformatf("v%0d_valid", i), {31'd0, w_valid}, {31'd0, vec[i].ev});
      chk($sformatf("v%0d_data", i), w_data, vec[i].ed);
      chk($sformatf("v%0d_bytes", i), {29'd0, w_bytes}, {29'd0, vec[i].eb});
      chk($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, vec[i].el});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vec[i].eo});
      chk($sformatf("v%0d_cnt", i), {16'd0, sample_cnt}, {16'd0, vec[i].ec});
    end

    // Five full words with the consumer stalled: the fifth one is dropped.
    for (int k = 0; k < 5; k++) begin
      words[k] = {8'(16*k+4), 8'(16*k+3), 8'(16*k+2), 8'(16*k+1)};
      push_word(words[k], 1'b0);
      if (k == 3) begin
        chk("ovf_level4", {29'd0, level}, 32'd4);
        chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
    end
    chk("ovf_level_full", {29'd0, level}, 32'd4);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) drain_check($sformatf("ovf_drain%0d", k), words[k]);
    chk("ovf_empty", {31'd0, w_valid}, 32'd0);
    chk("ovf_level0", {29'd0, level}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Asynchronous reset with one word queued and two bytes packed.
    push_word(32'hDDCCBBAA, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("pre_rst_level", {29'd0, level}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, w_valid}, 32'd0);
    chk("arst_data", w_data, 32'd0);
    chk("arst_bytes", {29'd0, w_bytes}, 32'd0);
    chk("arst_level", {29'd0, level}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_cnt", {16'd0, sample_cnt}, 32'd0);
    #1;
    reset = 1'b0;
    push_word(32'h58575655, 1'b0);
    chk("post_rst_data", w_data, 32'h58575655);
    chk("post_rst_bytes", {29'd0, w_bytes}, 32'd4);
    chk("post_rst_level", {29'd0, level}, 32'd1);
    chk("post_rst_cnt", {16'd0, sample_cnt}, 32'd4);

    // Full FIFO, and the completing byte arrives while the head is being popped.
    words[0] = 32'h58575655;
    for (int k = 1; k < 5; k++) words[k] = {8'(k+8'h60), 8'(k+8'h50), 8'(k+8'h40), 8'(k+8'h30)};
    for (int k = 1; k < 4; k++) push_word(words[k], 1'b0);
    chk("full_level", {29'd0, level}, 32'd4);
    push_word(words[4], 1'b1);
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 1; k < 5; k++) drain_check($sformatf("pp_drain%0d", k), words[k]);
    chk("pp_level0", {29'd0, level}, 32'd0);

    // The sample counter wraps: 65537 pulses leave it at 1.
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
    chk("wrap_cnt", {16'd0, sample_cnt}, 32'd1);
    chk("wrap_ovf", {31'd0, overflow}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_flush_bytes", {29'd0, w_bytes}, 32'd1);
    chk("wrap_flush_data", w_data, 32'h00000000);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("lane0_flush_valid", {31'd0, w_valid}, 32'd0);
    chk("lane0_flush_cnt", {16'd0, sample_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
